normalise_seq: RTL
==================

# normalise_seq

- Parametrised, handshaked, multi-cycle normaliser for the BF16/INT8 add-subtract datapath.
- Sits after the mantissa adder. Takes the raw two's-complement sum, the pre-aligned exponent and the mode.
- Produces the sign, the normalised mantissa (one left-shift per cycle), the exponent, and overflow/underflow flags.
- Adds over the earlier combinational normaliser: width generics, a guard bit, exponent-underflow clamping, valid/ready flow control and optional rounding.

## Interface
- MANT_W, 8, output mantissa width including hidden bit
- EXP_W, 8, exponent width
- SUM_W, MANT_W+3, adder result width; sign bit at SUM_W-2
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands (high in IDLE)
- int8  in  1  1 = integer mode, 0 = float mode
- signa_int, signb_int  in  1 each  operand signs (integer overflow check)
- mantissa_sum  in  SUM_W  adder result
- exponent_res  in  EXP_W  pre-normalisation exponent
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- mantissa_final  out  MANT_W  result mantissa / integer
- exponent_final  out  EXP_W  result exponent
- sign_res  out  1  result sign
- overflow  out  1  integer overflow or exponent saturated to all-ones
- underflow  out  1  exponent reached 0 before normalisation completed

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid & in_ready, capture all inputs, go CHECK.
  - CHECK: compute sign, magnitude and the zero/integer cases; go DONE, or load the shift register and go SHIFT.
  - SHIFT: one left shift per cycle; on exit go ROUND (when the macro is defined) or DONE.
  - ROUND: apply rounding; go DONE.
  - DONE: out_valid=1. On out_ready go IDLE.
- Sign and magnitude:
  - sign_res = mantissa_sum[SUM_W-2].
  - mag = sign ? -sum : sum, in SUM_W bits.
- Zero case: mag[SUM_W-2:0]==0 → mantissa 0, exponent 0, flags 0.
- Integer mode:
  - mantissa_final = mantissa_sum[MANT_W-1:0]; exponent_final = 0.
  - overflow=1 when both signs are 0 and result bit MANT_W-1 is 1, or both signs are 1 and that bit is 0.
- Float mode:
  - Shift register R = mag[MANT_W:0], MANT_W+1 bits. Mantissa = R[MANT_W:1]; R[0] is the guard bit.
  - Exponent E = exponent_res.
  - Special case mag[MANT_W+1]=1 (most negative sum only): mantissa = 1000…0, E+1, no shift.
- Each SHIFT cycle:
  - Exit if R[MANT_W]=1.
  - Else, if E==0: exit with underflow=1.
  - Else: R<<=1 (zero fill), E-=1.
  - Termination is guaranteed after at most MANT_W shifts.
- Float overflow: overflow=1 when final E is all-ones.
- Outputs are registered. They are stable, and all inputs are ignored, from CHECK until the DONE handshake.

## Timing
- Reset values: out_valid=0, mantissa_final=0, exponent_final=0, sign_res=0, overflow=0, underflow=0, state=IDLE, in_ready=1.
- Latency is counted from the accept edge = cycle 0:
  - Zero / integer result: out_valid in cycle 2.
  - Float with k shifts: out_valid in cycle 3+k.
  - ROUND adds 1 cycle.
- Throughput: one operation in flight. in_ready=0 from CHECK through DONE.
- out_valid & out_ready in DONE → IDLE next cycle; the next accept is possible that cycle.
- out_ready held low in DONE → outputs and out_valid held indefinitely.
- rst_n asserted in any state → immediate return to reset values. A partial result is never emitted.

## Configuration
- NORM_ROUND_EN defined:
  - ROUND state is present. Round-to-nearest-even on the guard bit: increment the mantissa when guard=1 and mantissa lsb=1.
  - Carry out of the mantissa → mantissa = 1000…0, E+1, overflow if E becomes all-ones.
  - ROUND is skipped (still one cycle) for underflow results.
- Undefined: the guard bit is truncated and there is no ROUND state.

## Structure
- Package norm_pkg: FSM state enum (IDLE, CHECK, SHIFT, ROUND, DONE) and localparam helpers for the SUM_W and sign-bit index.
- One sub-module, norm_round: combinational RNE incrementer with carry and exponent adjust. Instantiated only under NORM_ROUND_EN.

## Test plan
Defaults apply (MANT_W=8, SUM_W=11), with exponent_res=0x80 unless stated.
- Float, already normalised: sum=0x180 → mant 0xC0, exp 0x80, sign 0, out_valid cycle 3.
- Float, negative: sum=0x7D0 → sign 1, 3 shifts, mant 0xC0, exp 0x7D, out_valid cycle 6.
- Integer overflow: int8=1, signa=signb=0, sum=0x090 → mant 0x90, exp 0, overflow 1, cycle 2.
- Underflow and zero:
  - exponent_res=0x02, sum=0x010 → mant 0x20, exp 0, underflow 1.
  - sum=0x400 → mant 0, exp 0.
- Rounding: sum=0x1FF → with NORM_ROUND_EN: mant 0x80, exp 0x81; without: mant 0xFF, exp 0x80.
- Flow control and reset:
  - out_ready low 5 cycles in DONE → outputs held, in_ready 0.
  - rst_n pulsed during SHIFT → all outputs 0, in_ready 1, no out_valid.

Source files
------------

// File: rtl/norm_pkg.sv
// norm_pkg -- shared types and width helpers for the sequential normaliser.
//   norm_state_e  : FSM state encoding (IDLE, CHECK, SHIFT, ROUND, DONE)
//   norm_sum_w    : adder result width for a given mantissa width
//   norm_sign_idx : index of the sign bit inside the adder result
package norm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SHIFT = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } norm_state_e;

  // The adder result carries the hidden bit, a guard bit, the sign and one
  // extra carry bit above the mantissa.
  function automatic int norm_sum_w(input int mant_w);
    return mant_w + 3;
  endfunction

  function automatic int norm_sign_idx(input int sum_w);
    return sum_w - 2;
  endfunction

endpackage

// File: rtl/norm_round.sv
// norm_round -- combinational round-to-nearest-even on a single guard bit.
//   mant_i  : truncated mantissa (hidden bit at MSB)
//   guard_i : first bit below the mantissa lsb
//   exp_i   : exponent belonging to mant_i
//   mant_o  : rounded mantissa
//   exp_o   : exponent after a possible carry-out renormalisation
//   ovf_o   : exponent ended up all-ones
// Only instantiated when NORM_ROUND_EN is defined.
module norm_round #(
  parameter int MANT_W = 8,
  parameter int EXP_W  = 8
) (
  input  logic [MANT_W-1:0] mant_i,
  input  logic              guard_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic [MANT_W-1:0] mant_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic              ovf_o
);

  localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);

  logic [MANT_W:0] inc_w;

  // Without sticky bits a tie is guard=1 alone; round up only toward an even lsb.
  assign inc_w = {1'b0, mant_i} + {{MANT_W{1'b0}}, guard_i & mant_i[0]};

  always_comb begin
    mant_o = inc_w[MANT_W-1:0];
    exp_o  = exp_i;
    if (inc_w[MANT_W]) begin
      // All-ones mantissa rolled over: renormalise to 1.000 and bump the
      // exponent, which saturates at all-ones.
      mant_o = {1'b1, {(MANT_W-1){1'b0}}};
      exp_o  = (&exp_i) ? exp_i : exp_i + E_ONE;
    end
    ovf_o = &exp_o;
  end

endmodule

// File: rtl/normalise_seq.sv
// normalise_seq -- handshaked multi-cycle normaliser for the BF16/INT8
// add/subtract datapath. Accepts the raw two's-complement adder sum and
// the pre-aligned exponent, normalises with one left shift per cycle.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : operand handshake (ready only in IDLE)
//   int8               : 1 = integer result, 0 = float result
//   signa_int/signb_int: operand signs for the integer overflow check
//   mantissa_sum       : adder result, sign at SUM_W-2
//   exponent_res       : exponent before normalisation
//   out_valid/out_ready: result handshake, result held until accepted
//   mantissa_final, exponent_final, sign_res, overflow, underflow: result
// Optional feature: define NORM_ROUND_EN to add a ROUND state performing
// round-to-nearest-even on the guard bit; otherwise the guard is truncated.
module normalise_seq import norm_pkg::*; #(
  parameter int MANT_W = 8,
  parameter int EXP_W  = 8,
  parameter int SUM_W  = norm_sum_w(MANT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              int8,
  input  logic              signa_int,
  input  logic              signb_int,
  input  logic [SUM_W-1:0]  mantissa_sum,
  input  logic [EXP_W-1:0]  exponent_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mantissa_final,
  output logic [EXP_W-1:0]  exponent_final,
  output logic              sign_res,
  output logic              overflow,
  output logic              underflow
);

  localparam int SGN = norm_sign_idx(SUM_W);
  localparam int RW  = MANT_W + 1;  // mantissa plus guard bit
  localparam logic [EXP_W-1:0] E_ONE = EXP_W'(1);

  norm_state_e       state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              int8_q, int8_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [RW-1:0]     r_q, r_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  expo_q, expo_d;
  logic              sign_q, sign_d;
  logic              ovf_q, ovf_d;
  logic              uf_q, uf_d;

  logic [SUM_W-1:0]  mag_w;
  logic              int_ovf_w;
  logic [EXP_W-1:0]  e_inc_w;
  logic              shift_done_w;

  assign mag_w     = sum_q[SGN] ? -sum_q : sum_q;
  // Same-sign operands whose result sign disagrees have overflowed.
  assign int_ovf_w = (~sa_q & ~sb_q &  sum_q[MANT_W-1]) |
                     ( sa_q &  sb_q & ~sum_q[MANT_W-1]);
  assign e_inc_w   = (&e_q) ? e_q : e_q + E_ONE;
  assign shift_done_w = r_q[RW-1] | (e_q == '0);

`ifdef NORM_ROUND_EN
  logic              ufl_q, ufl_d;  // SHIFT ended on exponent underflow
  logic [MANT_W-1:0] rnd_mant_w;
  logic [EXP_W-1:0]  rnd_exp_w;
  logic              rnd_ovf_w;

  norm_round #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_round (
    .mant_i  (r_q[RW-1:1]),
    .guard_i (r_q[0]),
    .exp_i   (e_q),
    .mant_o  (rnd_mant_w),
    .exp_o   (rnd_exp_w),
    .ovf_o   (rnd_ovf_w)
  );
`endif

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    int8_d  = int8_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    r_d     = r_q;
    e_d     = e_q;
    mant_d  = mant_q;
    expo_d  = expo_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    uf_d    = uf_q;
`ifdef NORM_ROUND_EN
    ufl_d   = ufl_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sum_d   = mantissa_sum;
          e_d     = exponent_res;
          int8_d  = int8;
          sa_d    = signa_int;
          sb_d    = signb_int;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mag_w[SGN:0] == '0) begin
          mant_d  = '0;
          expo_d  = '0;
          sign_d  = sum_q[SGN];
          ovf_d   = 1'b0;
          uf_d    = 1'b0;
          state_d = S_DONE;
        end else if (int8_q) begin
          mant_d  = sum_q[MANT_W-1:0];
          expo_d  = '0;
          sign_d  = sum_q[SGN];
          ovf_d   = int_ovf_w;
          uf_d    = 1'b0;
          state_d = S_DONE;
        end else if (mag_w[MANT_W+1]) begin
          // Only the most negative sum reaches here: its magnitude is one
          // bit too wide, so pre-normalise it to 1.000 with E+1.
          r_d     = {1'b1, {(RW-1){1'b0}}};
          e_d     = e_inc_w;
          state_d = S_SHIFT;
        end else begin
          r_d     = mag_w[MANT_W:0];
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (shift_done_w) begin
`ifdef NORM_ROUND_EN
          ufl_d   = ~r_q[RW-1];
          state_d = S_ROUND;
`else
          mant_d  = r_q[RW-1:1];
          expo_d  = e_q;
          sign_d  = sum_q[SGN];
          ovf_d   = &e_q;
          uf_d    = ~r_q[RW-1];
          state_d = S_DONE;
`endif
        end else begin
          r_d = r_q << 1;
          e_d = e_q - E_ONE;
        end
      end
`ifdef NORM_ROUND_EN
      S_ROUND: begin
        sign_d = sum_q[SGN];
        if (ufl_q) begin
          // Denormal-range results are passed through unrounded.
          mant_d = r_q[RW-1:1];
          expo_d = e_q;
          ovf_d  = 1'b0;
          uf_d   = 1'b1;
        end else begin
          mant_d = rnd_mant_w;
          expo_d = rnd_exp_w;
          ovf_d  = rnd_ovf_w;
          uf_d   = 1'b0;
        end
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      int8_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      r_q     <= '0;
      e_q     <= '0;
      mant_q  <= '0;
      expo_q  <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      uf_q    <= 1'b0;
`ifdef NORM_ROUND_EN
      ufl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      int8_q  <= int8_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      r_q     <= r_d;
      e_q     <= e_d;
      mant_q  <= mant_d;
      expo_q  <= expo_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      uf_q    <= uf_d;
`ifdef NORM_ROUND_EN
      ufl_q   <= ufl_d;
`endif
    end
  end

  assign in_ready       = (state_q == S_IDLE);
  assign out_valid      = (state_q == S_DONE);
  assign mantissa_final = mant_q;
  assign exponent_final = expo_q;
  assign sign_res       = sign_q;
  assign overflow       = ovf_q;
  assign underflow      = uf_q;

endmodule
